// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wrapping to 0 after the last cycle.
module mux_scan_dwell_cnt #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LastVal = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: dwells on each channel, samples on its last cycle and
// publishes all four samples at once. Optional parity output under MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              mux_y_in,
  output logic [SEL_W-1:0]  sel_out,
  output logic              busy_out,
  output logic              done_out,
`ifdef MUX_SCAN_PARITY_EN
  output logic              parity_out,
`endif
  output logic [NUM_CH-1:0] scan_out
);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be in 1..255");
  end
  if (CNT_W < 32 && (32'd1 << CNT_W) <= DWELL) begin : g_bad_cnt_w
    $error("mux_scan_ctrl: CNT_W too narrow for DWELL");
  end

  scan_state_t       state_q, state_d;
  logic [SEL_W-1:0]  chan_q, chan_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] scan_q, scan_d;
  logic              cnt_clr, cnt_en, cnt_last;

  mux_scan_dwell_cnt #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk  (clk_in),
    .rst  (rst_in),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    shadow_d = shadow_q;
    scan_d   = scan_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = SCAN;
          chan_d  = '0;
          cnt_clr = 1'b1;
        end
      end
      SCAN: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          shadow_d[chan_q] = mux_y_in;
          if (chan_q == SEL_W'(NUM_CH - 1)) begin
            // Last sample is folded in directly so the word is complete in the DONE cycle.
            state_d = DONE;
            chan_d  = '0;
            scan_d  = shadow_d;
          end else begin
            chan_d = chan_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      shadow_q <= '0;
      scan_q   <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      shadow_q <= shadow_d;
      scan_q   <= scan_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^scan_d;
    end
  end

  assign parity_out = parity_q;
`endif

  assign sel_out  = chan_q;
  assign busy_out = (state_q == SCAN);
  assign done_out = (state_q == DONE);
  assign scan_out = scan_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl at DWELL = 1, 2, 3 side by side, each fed by a reference 4:1 mux
// and checked every cycle against a cycle-count model of the scan.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [3];
  logic       start [3];
  logic [3:0] d     [3];
  logic       mux_y [3];
  logic [1:0] sel   [3];
  logic       busy  [3];
  logic       done  [3];
  logic [3:0] scan  [3];
  logic       parity[3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    assign mux_y[gi] = d[gi][sel[gi]];
    mux_scan_ctrl #(
      .DWELL (gi + 1),
      .CNT_W (8)
    ) dut (
      .clk_in     (clk),
      .rst_in     (rst[gi]),
      .start_in   (start[gi]),
      .mux_y_in   (mux_y[gi]),
      .sel_out    (sel[gi]),
      .busy_out   (busy[gi]),
      .done_out   (done[gi]),
`ifdef MUX_SCAN_PARITY_EN
      .parity_out (parity[gi]),
`endif
      .scan_out   (scan[gi])
    );
`ifndef MUX_SCAN_PARITY_EN
    assign parity[gi] = 1'b0;
`endif
  end

  int total = 0;
  int bad   = 0;

  // Model: t = 0 idle, 1..4D scanning, 4D+1 the done cycle.
  int         t        [3];
  logic [3:0] m_shadow [3];
  logic [3:0] m_scan   [3];
  logic [3:0] lit      [3];

  task automatic chk(input int i, input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL dwell=%0d %s: got %0d, expected %0d at %0t", i + 1, nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      int dw;
      dw = i + 1;
      if (rst[i]) begin
        t[i] = 0;
        m_scan[i] = 4'b0;
      end else if (t[i] == 0) begin
        t[i] = start[i] ? 1 : 0;
      end else if (t[i] <= 4 * dw) begin
        if (t[i] % dw == 0) m_shadow[i][t[i] / dw - 1] = d[i][t[i] / dw - 1];
        t[i]++;
        if (t[i] == 4 * dw + 1) m_scan[i] = m_shadow[i];
      end else begin
        t[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      int dw;
      dw = i + 1;
      chk(i, "busy", int'(busy[i]), int'(t[i] >= 1 && t[i] <= 4 * dw));
      chk(i, "done", int'(done[i]), int'(t[i] == 4 * dw + 1));
      chk(i, "scan", int'(scan[i]), int'(m_scan[i]));
      if (t[i] != 4 * dw + 1) chk(i, "sel", int'(sel[i]), (t[i] == 0) ? 0 : (t[i] - 1) / dw);
`ifdef MUX_SCAN_PARITY_EN
      chk(i, "parity", int'(parity[i]), int'(^m_scan[i]));
`endif
    end
  endtask

  initial begin
    lit[0] = 4'b0110;
    lit[1] = 4'b1010;
    lit[2] = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b1; d[i] = 4'h0;
      t[i] = 0; m_shadow[i] = 4'h0; m_scan[i] = 4'h0;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk(i, "reset_scan", int'(scan[i]), 0);
      chk(i, "reset_busy", int'(busy[i]), 0);
      rst[i] = 1'b0; start[i] = 1'b0;
    end
    step();

    // Start held high: done must recur every 4D+2 cycles, first word pinned literally.
    for (int c = 0; c < 42; c++) begin
      for (int i = 0; i < 3; i++) begin
        start[i] = 1'b1;
        if (i == 0) d[i] = 4'b0110;
        else if (i == 1) d[i] = 4'b1010;
        else d[i] = (c <= 6) ? 4'hF : 4'h0;
      end
      step();
      for (int i = 0; i < 3; i++) begin
        int dw;
        dw = i + 1;
        chk(i, "lit_done", int'(done[i]), int'((c + 1) % (4 * dw + 2) == 4 * dw + 1));
        if (c + 1 == 4 * dw) chk(i, "lit_hold", int'(scan[i]), 0);
        if (c + 1 == 4 * dw + 1) chk(i, "lit_scan", int'(scan[i]), int'(lit[i]));
      end
    end
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (16) step();

    // Reset asserted in cycle 5 of a scan.
    for (int i = 0; i < 3; i++) begin start[i] = 1'b1; d[i] = 4'b1111; end
    step();
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk(i, "midrst_scan", int'(scan[i]), 0);
      chk(i, "midrst_busy", int'(busy[i]), 0);
      chk(i, "midrst_sel", int'(sel[i]), 0);
      chk(i, "midrst_done", int'(done[i]), 0);
      rst[i] = 1'b0;
    end

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        start[i] = ($urandom_range(0, 2) == 0);
        rst[i]   = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 2) == 0) d[i] = 4'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Upstream sequencer for the 4:1 channel mux. It drives the mux select through channels 0 to 3, holding each channel for a programmable number of cycles. On the last cycle of each channel it samples the mux output. When the scan is complete it publishes all four samples atomically as a 4-bit word, with a start/busy/done handshake toward the controlling logic.

## Interface
Parameters:
- DWELL, default 2: cycles `sel_out` is held per channel. Legal range 1 to 255; values outside it are rejected at elaboration.
- CNT_W, default 8: dwell counter width. Must satisfy 2**CNT_W > DWELL.

Ports:
- clk_in, input, 1: single clock. All logic is rising-edge.
- rst_in, input, 1: reset, synchronous, active-high.
- start_in, input, 1: scan request. Sampled only in IDLE.
- mux_y_in, input, 1: mux output. Combinational from `sel_out`.
- sel_out, output, 2: channel select driven to the mux.
- busy_out, output, 1: high while a scan is in progress.
- done_out, output, 1: single-cycle pulse when `scan_out` updates.
- scan_out, output, 4: bit i holds the channel-i sample from the last completed scan.
- parity_out, output, 1: XOR of `scan_out`. Present only with the macro (see Configuration).

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `sel_out` = 0, `busy_out` = 0.
  - `start_in` = 1 moves to SCAN: channel index cleared, dwell counter cleared.
- SCAN:
  - `busy_out` = 1, `sel_out` = channel index.
  - The dwell counter increments each cycle.
  - When counter == DWELL-1, `mux_y_in` is captured into `shadow[channel]` and the counter clears.
  - If channel < 3, channel increments; otherwise go to DONE.
- DONE:
  - `scan_out` <= shadow; all 4 bits update on the same edge.
  - `done_out` = 1 and `busy_out` = 0 for exactly this cycle.
  - Unconditional return to IDLE.
- `start_in` in SCAN or DONE is ignored. It is not queued.
- `scan_out` holds its value between scans. It changes only on entry to the DONE cycle.
- Shadow bits are internal. A partial scan never reaches `scan_out`.
- DWELL = 1 is legal: one cycle per channel, with a sample taken every cycle. This works because the mux is combinational.

## Timing
- Reset values: state IDLE; `sel_out` 0; `busy_out` 0; `done_out` 0; `scan_out` 4'b0000; `parity_out` 0; shadow 0; counters 0.
- Cycle numbering, with `start_in` high in IDLE at cycle 0:
  - Cycles 1 to 4·DWELL: `busy_out` = 1.
  - Channel k drives `sel_out` = k during cycles k·DWELL+1 to (k+1)·DWELL.
  - Channel k is sampled at the end of cycle (k+1)·DWELL.
- Cycle 4·DWELL+1: `done_out` = 1, new `scan_out` valid, `busy_out` = 0.
- Cycle 4·DWELL+2: IDLE. The earliest accepted restart is `start_in` high here.
- Start-to-done latency is 4·DWELL+1 cycles. Minimum scan period is 4·DWELL+2 cycles.
- Reset mid-scan: on the next edge, all outputs take their reset values. `done_out` does not fire, and `scan_out` clears to 0 (not held).
- Reset and start in the same cycle: reset wins.
- `sel_out` is registered and glitch-free. It changes only at channel boundaries and on reset.

## Configuration
- Macro: `MUX_SCAN_PARITY_EN`.
- With the macro defined:
  - Port `parity_out` exists, registered.
  - It updates on the same edge as `scan_out`, to XOR of the new word.
  - Reset value 0.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `mux_scan_pkg` holds:
  - state enum `scan_state_t` (IDLE, SCAN, DONE);
  - constants `NUM_CH` = 4 and `SEL_W` = 2.
- Sub-module `mux_scan_dwell_cnt`: parameterised CNT_W/DWELL counter with `clr` and `en` inputs and a `last` output. It is the only natural split.
- The FSM, channel index, shadow and output registers stay in the top module.

## Test plan
- DWELL=2, mux driven by a reference 4:1 mux with d = 4'b1010, one start pulse:
  - `sel_out` sequence 0,0,1,1,2,2,3,3;
  - `done_out` pulses at cycle 9;
  - `scan_out` = 4'b1010; `busy_out` high for cycles 1 to 8 only.
- DWELL=1, d = 4'b0110:
  - `done_out` at cycle 5;
  - `scan_out` = 4'b0110; `sel_out` sequence 0,1,2,3.
- DWELL=3, d changes from 4'b1111 to 4'b0000 after cycle 6:
  - channels 0 and 1 capture 1, channels 2 and 3 capture 0;
  - `scan_out` = 4'b0011; the old `scan_out` holds until cycle 13.
- `start_in` held high continuously, DWELL=2:
  - `done_out` pulses at cycles 9, 19, 29 (period 10);
  - starts during SCAN and DONE are ignored.
- `rst_in` asserted at cycle 5 of a scan:
  - next cycle `sel_out` = 0, `busy_out` = 0, `scan_out` = 0;
  - no `done_out`; a fresh start then completes normally.
- With `MUX_SCAN_PARITY_EN`, d = 4'b0111: `parity_out` = 1 in the same cycle `done_out` = 1.
